// File: rtl/t_ff_sync_counter_pkg.sv
// Shared constants and helpers for T-flip-flop based counter stages.
package t_ff_sync_counter_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_MOD   = 10;

  // Width-sized all-zero count value
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Count direction encoding carried on up_dn
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Terminal count for a modulus
  function automatic int unsigned max_cnt(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit synchronous T flip-flop: flips on the rising edge when t is high.
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // Toggle storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_ff_sync_counter.sv
// Modulo-MOD up/down counter whose state bits are T flip-flop cells.
// Every state change, including load and reset, is expressed as a toggle vector.
module t_ff_sync_counter
  import t_ff_sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH,
  parameter int unsigned MOD   = CNT_MOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_cnt(MOD));
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(CNT_ZERO);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Next count and wrap: reset > load > en > hold
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (reset) begin
      q_next = ZERO;
    end else if (load) begin
      q_next = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (dir_e'(up_dn) == DIR_UP) begin
        // Out-of-range states also fold back to zero on an up step
        if (q >= MAX_CNT) begin
          q_next    = ZERO;
          wrap_next = 1'b1;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (q == ZERO) begin
          q_next    = MAX_CNT;
          wrap_next = 1'b1;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // Bits that must flip this edge to reach the next count
  assign t_vec = q_next ^ q;

  // One T cell per count bit
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    t_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

  // Registered single-cycle boundary pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule
